// File: rtl/power_iter_pkg.sv
// power_iter_pkg: state encoding and arithmetic helpers shared by the power-iteration engine and its MAC.
package power_iter_pkg;

  typedef enum logic [2:0] {IDLE, MUL, NORM, CHECK, DONE} state_t;

  function automatic int acc_w(input int data_w, input int n);
    return 2 * data_w + $clog2(n);
  endfunction

  function automatic int cnt_w(input int max_iter);
    return $clog2(max_iter + 1);
  endfunction

  // Symmetric clamp to +/-(2^(data_w-1)-1); operands are carried in 64 bits, so ACC_W must stay <= 64.
  function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int data_w);
    logic signed [63:0] lim;
    lim = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    if (x > lim) return lim;
    if (x < -lim) return -lim;
    return x;
  endfunction

  function automatic logic [31:0] abs_diff(input logic signed [31:0] a, input logic signed [31:0] b);
    logic signed [31:0] d;
    d = a - b;
    return (d < 0) ? 32'(-d) : 32'(d);
  endfunction

endpackage

// File: rtl/power_iter_mac.sv
// power_iter_mac: single signed multiply-accumulate with per-row clear and a saturating rescaled output.
module power_iter_mac
  import power_iter_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 12,
  parameter int ACC_W  = 35
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] result
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    base;
  logic signed [ACC_W-1:0]    sum;
  logic signed [ACC_W-1:0]    acc;

  // result already includes this cycle's product, so the last column of a row can be captured immediately
  always_comb begin
    prod   = a * b;
    base   = clear ? '0 : acc;
    sum    = base + ACC_W'(prod);
    result = DATA_W'(sat(64'(sum >>> FRAC_W), DATA_W));
  end

  always_ff @(posedge clk) begin
    if (!rst) acc <= '0;
    else if (en) acc <= sum;
  end

endmodule

// File: rtl/power_iter_engine.sv
// power_iter_engine: sequential power iteration v(k+1) = A*v(k) on one shared MAC until convergence or MAX_ITER.
// Define POWER_ITER_NORM_EN to add a per-iteration normalisation step that keeps iterates clear of saturation.
module power_iter_engine
  import power_iter_pkg::*;
#(
  parameter int  SIZE_N   = 8,
  parameter int  MAX_ITER = 8,
  parameter int  DATA_W   = 16,
  parameter int  FRAC_W   = 12,
  parameter int  TOL      = 4,
  localparam int CNT_W    = cnt_w(MAX_ITER)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] matrix_in [SIZE_N][SIZE_N],
  input  logic signed [DATA_W-1:0] vector_in [SIZE_N],
  output logic                     busy,
  output logic                     done,
  output logic                     converged,
  output logic                     timeout,
  output logic signed [DATA_W-1:0] vector_out [SIZE_N],
  output logic [CNT_W-1:0]         iter_count
);

  localparam int               ACC_W    = acc_w(DATA_W, SIZE_N);
  localparam int               IDX_W    = $clog2(SIZE_N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE_N - 1);

  state_t                   state, state_n;
  logic [IDX_W-1:0]         row, col;
  logic signed [DATA_W-1:0] cur [SIZE_N];
  logic signed [DATA_W-1:0] nxt [SIZE_N];
  logic signed [DATA_W-1:0] mac_result;
  logic                     mac_en, row_end, conv, last_iter;

  power_iter_mac #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clear (col == '0),
    .en    (mac_en),
    .a     (matrix_in[row][col]),
    .b     (cur[col]),
    .result(mac_result)
  );

`ifdef POWER_ITER_NORM_EN
  logic signed [DATA_W-1:0] nxt_norm [SIZE_N];
  logic [31:0]              norm_max;
  int                       norm_shift;

  // The smallest valid shift equals the number of shifts that still leave the peak at or above 2^(DATA_W-2).
  always_comb begin
    norm_max   = '0;
    norm_shift = 0;
    for (int i = 0; i < SIZE_N; i++)
      if (abs_diff(32'(nxt[i]), 32'sd0) > norm_max) norm_max = abs_diff(32'(nxt[i]), 32'sd0);
    for (int s = 0; s < DATA_W; s++)
      if ((norm_max >> s) >= 32'(2 ** (DATA_W - 2))) norm_shift = norm_shift + 1;
    for (int i = 0; i < SIZE_N; i++)
      nxt_norm[i] = nxt[i] >>> norm_shift;
  end
`endif

  always_comb begin
    state_n   = state;
    mac_en    = 1'b0;
    row_end   = (col == LAST_IDX);
    last_iter = (int'(iter_count) + 1 == MAX_ITER);
    conv      = 1'b1;
    for (int i = 0; i < SIZE_N; i++)
      if (abs_diff(32'(nxt[i]), 32'(cur[i])) > 32'(TOL)) conv = 1'b0;
    case (state)
      IDLE:  if (start) state_n = MUL;
      MUL: begin
        mac_en = 1'b1;
        if (row_end && row == LAST_IDX)
`ifdef POWER_ITER_NORM_EN
          state_n = NORM;
`else
          state_n = CHECK;
`endif
      end
      NORM:    state_n = CHECK;
      CHECK:   state_n = (conv || last_iter) ? DONE : MUL;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Results are registered on the way into DONE so they are already valid while done is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      row        <= '0;
      col        <= '0;
      cur        <= '{default: '0};
      nxt        <= '{default: '0};
      vector_out <= '{default: '0};
      converged  <= 1'b0;
      timeout    <= 1'b0;
      iter_count <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cur        <= vector_in;
          row        <= '0;
          col        <= '0;
          converged  <= 1'b0;
          timeout    <= 1'b0;
          iter_count <= '0;
        end
        MUL: begin
          col <= row_end ? '0 : col + 1'b1;
          if (row_end) begin
            nxt[row] <= mac_result;
            row      <= (row == LAST_IDX) ? '0 : row + 1'b1;
          end
        end
`ifdef POWER_ITER_NORM_EN
        NORM: nxt <= nxt_norm;
`endif
        CHECK: begin
          iter_count <= iter_count + 1'b1;
          if (state_n == DONE) begin
            vector_out <= nxt;
            converged  <= conv;
            timeout    <= ~conv;
          end else begin
            cur <= nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_power_iter_engine.sv
// tb_power_iter_engine: scoreboard bench for power_iter_engine; follows POWER_ITER_NORM_EN when it is defined.
`timescale 1ns/1ps
module tb_power_iter_engine;

  localparam int N        = 4;
  localparam int MAX_ITER = 8;
  localparam int DW       = 16;
  localparam int FW       = 12;
  localparam int TOL      = 4;
  localparam int CW       = $clog2(MAX_ITER + 1);
  localparam int ONE      = 1 << FW;
`ifdef POWER_ITER_NORM_EN
  localparam int ITER_LAT = N * N + 2;
`else
  localparam int ITER_LAT = N * N + 1;
`endif
  localparam int WAIT_LIMIT = MAX_ITER * ITER_LAT + 20;

  typedef int vec_t [N];
  typedef int mat_t [N][N];
  typedef struct packed {
    logic [N-1:0][DW-1:0] v;
    logic                 conv;
    int                   iters;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic signed [DW-1:0] matrix_in [N][N];
  logic signed [DW-1:0] vector_in [N];
  logic                 busy;
  logic                 done;
  logic                 converged;
  logic                 timeout;
  logic signed [DW-1:0] vector_out [N];
  logic [CW-1:0]        iter_count;

  exp_t expQ[$];
  int   checks    = 0;
  int   errors    = 0;
  int   doneCount = 0;
  int   runsSeen  = 0;

  power_iter_engine #(
    .SIZE_N(N), .MAX_ITER(MAX_ITER), .DATA_W(DW), .FRAC_W(FW), .TOL(TOL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .matrix_in (matrix_in),
    .vector_in (vector_in),
    .busy      (busy),
    .done      (done),
    .converged (converged),
    .timeout   (timeout),
    .vector_out(vector_out),
    .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) doneCount++;

  task automatic checkOutput(input string tag, input int got, input int expd);
    checks++;
    if (got !== expd) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, expd);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Reference power iteration straight from the algorithm: full-precision dot product, rescale, clamp.
  function automatic exp_t refModel(input mat_t a, input vec_t v0);
    exp_t   e;
    vec_t   cur;
    vec_t   nxt;
    longint acc;
    int     lim;
    bit     stop;
`ifdef POWER_ITER_NORM_EN
    int     m;
    int     s;
`endif
    lim  = (1 << (DW - 1)) - 1;
    e    = '0;
    cur  = v0;
    nxt  = v0;
    stop = 1'b0;
    for (int it = 1; it <= MAX_ITER; it++) begin
      if (!stop) begin
        for (int r = 0; r < N; r++) begin
          acc = 0;
          for (int c = 0; c < N; c++) acc += longint'(a[r][c]) * longint'(cur[c]);
          acc = acc >>> FW;
          if (acc > lim) acc = lim;
          else if (acc < -lim) acc = -lim;
          nxt[r] = int'(acc);
        end
`ifdef POWER_ITER_NORM_EN
        m = 0;
        for (int i = 0; i < N; i++) if (iabs(nxt[i]) > m) m = iabs(nxt[i]);
        s = 0;
        while ((m >>> s) >= (1 << (DW - 2))) s++;
        for (int i = 0; i < N; i++) nxt[i] = nxt[i] >>> s;
`endif
        e.conv = 1'b1;
        for (int i = 0; i < N; i++) if (iabs(nxt[i] - cur[i]) > TOL) e.conv = 1'b0;
        e.iters = it;
        if (e.conv || it == MAX_ITER) stop = 1'b1;
        else cur = nxt;
      end
    end
    for (int i = 0; i < N; i++) e.v[i] = DW'(nxt[i]);
    return e;
  endfunction

  task automatic makeDiag(input vec_t d, output mat_t m);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) m[r][c] = (r == c) ? d[r] : 0;
  endtask

  task automatic loadInputs(input mat_t a, input vec_t v);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) matrix_in[r][c] = DW'(a[r][c]);
    for (int i = 0; i < N; i++) vector_in[i] = DW'(v[i]);
  endtask

  // Drive one start pulse (or keep it held) and log the expected outcome in the scoreboard.
  task automatic applyStimulus(input mat_t a, input vec_t v, input bit hold);
    loadInputs(a, v);
    expQ.push_back(refModel(a, v));
    start = 1'b1;
    @(posedge clk); #1;
    checkOutput("busy_rise", int'(busy), 1);
    start = hold;
  endtask

  // cnt counts cycles with the start cycle as 1, so the done cycle lands on iters*ITER_LAT+2.
  task automatic waitDone(input string tag, input int cnt0);
    int   cnt;
    exp_t e;
    cnt = cnt0;
    while (!done && cnt < WAIT_LIMIT) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (expQ.size() == 0) begin
      checkOutput({tag, ".queue"}, 0, 1);
      return;
    end
    e = expQ.pop_front();
    if (!done) begin
      checkOutput({tag, ".done_wait"}, 0, 1);
      return;
    end
    runsSeen++;
    checkOutput({tag, ".cycles"}, cnt, e.iters * ITER_LAT + 2);
    checkOutput({tag, ".busy"}, int'(busy), 1);
    checkOutput({tag, ".iter"}, int'(iter_count), e.iters);
    checkOutput({tag, ".conv"}, int'(converged), int'(e.conv));
    checkOutput({tag, ".timeout"}, int'(timeout), int'(!e.conv));
    for (int i = 0; i < N; i++)
      checkOutput($sformatf("%s.v%0d", tag, i), int'(vector_out[i]), int'($signed(e.v[i])));
    @(posedge clk); #1;
    checkOutput({tag, ".done_pulse"}, int'(done), 0);
    checkOutput({tag, ".busy_fall"}, int'(busy), 0);
  endtask

  initial begin
    mat_t a;
    mat_t z;
    vec_t v;
    vec_t d;
    exp_t dummy;

    for (int r = 0; r < N; r++) begin
      v[r] = 0;
      for (int c = 0; c < N; c++) z[r][c] = 0;
    end
    rst   = 1'b0;
    start = 1'b0;
    loadInputs(z, v);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst.busy", int'(busy), 0);
    checkOutput("rst.done", int'(done), 0);
    checkOutput("rst.conv", int'(converged), 0);
    checkOutput("rst.timeout", int'(timeout), 0);
    checkOutput("rst.iter", int'(iter_count), 0);
    for (int i = 0; i < N; i++) checkOutput($sformatf("rst.v%0d", i), int'(vector_out[i]), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    d = '{ONE, ONE, ONE, ONE};
    makeDiag(d, a);
    v = '{100, -50, 0, 0};
    applyStimulus(a, v, 1'b0);
    waitDone("ident", 2);
    checkOutput("ident.fix_v0", int'(vector_out[0]), 100);
    checkOutput("ident.fix_v1", int'(vector_out[1]), -50);
    checkOutput("ident.fix_iter", int'(iter_count), 1);

    d = '{2 * ONE, ONE, ONE, ONE};
    makeDiag(d, a);
    v = '{1000, 1000, 0, 0};
    applyStimulus(a, v, 1'b0);
    waitDone("diag", 2);
`ifdef POWER_ITER_NORM_EN
    checkOutput("diag.fix_timeout", int'(timeout), 1);
    checkOutput("diag.fix_iter", int'(iter_count), MAX_ITER);
    checkOutput("diag.fix_v0", int'(vector_out[0]), 16000);
`else
    checkOutput("diag.fix_v0", int'(vector_out[0]), 32767);
    checkOutput("diag.fix_iter", int'(iter_count), 7);
`endif

    a = z;
    a[0][1] = ONE;
    a[1][0] = ONE;
    v = '{1000, 0, 0, 0};
    applyStimulus(a, v, 1'b0);
    waitDone("swap", 2);
    checkOutput("swap.fix_timeout", int'(timeout), 1);
    checkOutput("swap.fix_conv", int'(converged), 0);
    checkOutput("swap.fix_iter", int'(iter_count), MAX_ITER);

    d = '{ONE / 2, ONE / 2, ONE / 2, ONE / 2};
    makeDiag(d, a);
    v = '{1000, -1000, 200, 0};
    applyStimulus(a, v, 1'b0);
    waitDone("half", 2);
    checkOutput("half.fix_conv", int'(converged), 1);
    checkOutput("half.fix_timeout", int'(timeout), 0);
    checkOutput("half.fix_iter", int'(iter_count), MAX_ITER);
    checkOutput("half.fix_v0", int'(vector_out[0]), 3);
    checkOutput("half.fix_v1", int'(vector_out[1]), -4);

    // Abort the same long run mid-MUL; its scoreboard entry is discarded because no done may appear.
    applyStimulus(a, v, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    dummy = expQ.pop_back();
    checkOutput("abort.busy", int'(busy), 0);
    checkOutput("abort.v0", int'(vector_out[0]), 0);
    checkOutput("abort.conv", int'(converged), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    applyStimulus(a, v, 1'b0);
    waitDone("rerun", 2);
    checkOutput("rerun.fix_v0", int'(vector_out[0]), 3);

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) a[r][c] = int'($urandom_range(0, 2 * ONE)) - ONE;
    v = '{0, 0, 0, 0};
    applyStimulus(a, v, 1'b0);
    waitDone("zero", 2);
    checkOutput("zero.fix_conv", int'(converged), 1);
    checkOutput("zero.fix_iter", int'(iter_count), 1);
    checkOutput("zero.fix_v0", int'(vector_out[0]), 0);

    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < N; r++) begin
        v[r] = int'($urandom_range(0, 6000)) - 3000;
        for (int c = 0; c < N; c++) a[r][c] = int'($urandom_range(0, ONE)) - ONE / 2;
      end
      applyStimulus(a, v, 1'b0);
      waitDone($sformatf("rand%0d", k), 2);
    end

    // Start held high: one run only, then a fresh run accepted in the IDLE cycle right after done.
    d = '{ONE, ONE, ONE, ONE};
    makeDiag(d, a);
    v = '{7, -8, 9, -10};
    applyStimulus(a, v, 1'b1);
    waitDone("hold1", 2);
    expQ.push_back(refModel(a, v));
    @(posedge clk); #1;
    checkOutput("hold.restart", int'(busy), 1);
    start = 1'b0;
    waitDone("hold2", 2);

    checkOutput("done_count", doneCount, runsSeen);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
